// File: rtl/copy_fork_pkg.sv
// Shared types and defaults for the copy_fork one-place 4-phase fork.
package copy_fork_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RTZ  = 2'd2
    } hs_state_t;

endpackage

// File: rtl/copy_fork_out.sv
// One 4-phase output sender: IDLE -> REQ -> RTZ -> IDLE, req decoded from the state register.
module copy_fork_out
    import copy_fork_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic ack,
    output logic req,
    output logic idle
);

    hs_state_t state, state_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ:     if (ack)   state_nxt = RTZ;
            RTZ:     if (!ack)  state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    // An ack seen in IDLE changes nothing; req is a pure state decode of a flop.
    assign req  = (state == REQ);
    assign idle = (state == IDLE);

endmodule

// File: rtl/copy_fork.sv
// Clocked one-place fork: each L token is delivered once to R0 and once to R1 (4-phase, bundled data).
// Define COPY_FORK_ASSERT_EN to compile in simulation-only protocol assertions.
module copy_fork
    import copy_fork_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             L_req,
    input  logic [WIDTH-1:0] L_data,
    output logic             L_ack,
    output logic             R0_req,
    output logic [WIDTH-1:0] R0_data,
    input  logic             R0_ack,
    output logic             R1_req,
    output logic [WIDTH-1:0] R1_data,
    input  logic             R1_ack
);

    logic             accept;
    logic             idle0;
    logic             idle1;
    logic [WIDTH-1:0] token_q;

    // One-place buffering: a new token waits until both senders are back in IDLE.
    assign accept = L_req && !L_ack && idle0 && idle1;

    // NOTE: the token register is reset so the data outputs are defined from the first cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            L_ack   <= 1'b0;
            token_q <= '0;
        end else if (accept) begin
            L_ack   <= 1'b1;
            token_q <= L_data;
        end else if (!L_req) begin
            L_ack   <= 1'b0;
        end
    end

    copy_fork_out u_out0 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept),
        .ack   (R0_ack),
        .req   (R0_req),
        .idle  (idle0)
    );

    copy_fork_out u_out1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept),
        .ack   (R1_ack),
        .req   (R1_req),
        .idle  (idle1)
    );

    assign R0_data = token_q;
    assign R1_data = token_q;

`ifdef COPY_FORK_ASSERT_EN
    a_l_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (L_req && !L_ack) |=> (L_ack || !L_req || $stable(L_data)));

    a_l_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        $fell(L_req) |-> $past(L_ack));

    a_r0_ack_rise: assert property (@(posedge clk) disable iff (!rst_n)
        $rose(R0_ack) |-> R0_req);

    a_r1_ack_rise: assert property (@(posedge clk) disable iff (!rst_n)
        $rose(R1_ack) |-> R1_req);

    a_l_ack_rtz: assert property (@(posedge clk) disable iff (!rst_n)
        (!L_req && $past(!L_req)) |-> !L_ack);
`else
`endif

endmodule

// File: tb/tb_copy_fork.sv
// Directed self-checking bench for copy_fork: ordering, backpressure, simultaneous acks, mid-token reset.
module tb_copy_fork;

    logic       clk;
    logic       rst_n;
    logic       L_req;
    logic [3:0] L_data;
    logic       L_ack;
    logic       R0_req;
    logic [3:0] R0_data;
    logic       R0_ack;
    logic       R1_req;
    logic [3:0] R1_data;
    logic       R1_ack;

    int checks = 0;
    int errors = 0;

    copy_fork #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .L_req   (L_req),
        .L_data  (L_data),
        .L_ack   (L_ack),
        .R0_req  (R0_req),
        .R0_data (R0_data),
        .R0_ack  (R0_ack),
        .R1_req  (R1_req),
        .R1_data (R1_data),
        .R1_ack  (R1_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge, away from the active edge.
    task automatic cycle();
        @(negedge clk);
    endtask

    // Full L handshake; exp_wait is the number of cycles until L_ack is expected high.
    task automatic send_token(input logic [3:0] d, input int exp_wait, input string tag);
        int n;
        L_data = d;
        L_req  = 1'b1;
        cycle();
        n = 1;
        while (L_ack !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        check({tag, " L_ack latency"}, n, exp_wait);
        check({tag, " R0_req"}, R0_req, 1'b1);
        check({tag, " R1_req"}, R1_req, 1'b1);
        check({tag, " R0_data"}, R0_data, d);
        check({tag, " R1_data"}, R1_data, d);
        L_req = 1'b0;
        cycle();
        check({tag, " L_ack rtz"}, L_ack, 1'b0);
    endtask

    task automatic complete(input int p, input string tag);
        if (p == 0) R0_ack = 1'b1;
        else        R1_ack = 1'b1;
        cycle();
        check({tag, (p == 0) ? " R0_req drop" : " R1_req drop"},
              (p == 0) ? R0_req : R1_req, 1'b0);
        if (p == 0) R0_ack = 1'b0;
        else        R1_ack = 1'b0;
        cycle();
    endtask

    initial begin
        rst_n  = 1'b0;
        L_req  = 1'b0;
        L_data = 4'h0;
        R0_ack = 1'b0;
        R1_ack = 1'b0;
        #12;
        check("reset L_ack", L_ack, 1'b0);
        check("reset R0_req", R0_req, 1'b0);
        check("reset R1_req", R1_req, 1'b0);
        check("reset data", R0_data, 4'h0);
        cycle();
        rst_n = 1'b1;
        cycle();

        // Test 1: token 1010, R0 completes on the same edge that L_req falls, then R1.
        L_data = 4'b1010;
        L_req  = 1'b1;
        cycle();
        check("t1 L_ack", L_ack, 1'b1);
        check("t1 R0_req", R0_req, 1'b1);
        check("t1 R1_req", R1_req, 1'b1);
        check("t1 R0_data", R0_data, 4'b1010);
        check("t1 R1_data", R1_data, 4'b1010);
        L_req  = 1'b0;
        R0_ack = 1'b1;
        cycle();
        check("t1 L_ack rtz", L_ack, 1'b0);
        check("t1 R0_req drop", R0_req, 1'b0);
        check("t1 R1_req held", R1_req, 1'b1);
        R0_ack = 1'b0;
        cycle();
        check("t1 R1_req still", R1_req, 1'b1);
        complete(1, "t1");
        check("t1 data held", R1_data, 4'b1010);

        // Test 2: token 0101, R1 consumed before R0.
        send_token(4'b0101, 1, "t2");
        complete(1, "t2");
        check("t2 R0_req waiting", R0_req, 1'b1);
        complete(0, "t2");
        check("t2 R0_data", R0_data, 4'b0101);

        // Test 3: R1 stalls, new token 0011 is backpressured until R1 is IDLE.
        send_token(4'b1010, 1, "t3");
        complete(0, "t3");
        L_data = 4'b0011;
        L_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t3 backpressure L_ack", L_ack, 1'b0);
            check("t3 data held", R0_data, 4'b1010);
        end
        R1_ack = 1'b1;
        cycle();
        check("t3 R1_req drop", R1_req, 1'b0);
        check("t3 L_ack in RTZ", L_ack, 1'b0);
        R1_ack = 1'b0;
        cycle();
        check("t3 L_ack at IDLE", L_ack, 1'b0);
        cycle();
        check("t3 L_ack accept", L_ack, 1'b1);
        check("t3 R0_data", R0_data, 4'b0011);
        check("t3 R1_req", R1_req, 1'b1);
        L_req = 1'b0;
        cycle();
        complete(0, "t3b");
        complete(1, "t3b");

        // Test 4: simultaneous acks for 1111; next token accepted two cycles later.
        send_token(4'b1111, 1, "t4");
        R0_ack = 1'b1;
        R1_ack = 1'b1;
        cycle();
        check("t4 R0_req drop", R0_req, 1'b0);
        check("t4 R1_req drop", R1_req, 1'b0);
        R0_ack = 1'b0;
        R1_ack = 1'b0;
        L_data = 4'b0110;
        L_req  = 1'b1;
        cycle();
        check("t4 L_ack early", L_ack, 1'b0);
        cycle();
        check("t4 L_ack accept", L_ack, 1'b1);
        check("t4 R0_data", R0_data, 4'b0110);
        check("t4 R0_req", R0_req, 1'b1);
        check("t4 R1_req", R1_req, 1'b1);

        // Test 5: asynchronous reset mid-token, then a clean token 1000.
        #2;
        rst_n = 1'b0;
        L_req = 1'b0;
        #1;
        check("t5 reset L_ack", L_ack, 1'b0);
        check("t5 reset R0_req", R0_req, 1'b0);
        check("t5 reset R1_req", R1_req, 1'b0);
        check("t5 reset data", R1_data, 4'h0);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        send_token(4'b1000, 1, "t5");
        complete(0, "t5");
        complete(1, "t5");
        check("t5 final data", R1_data, 4'b1000);
        check("t5 idle L_ack", L_ack, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
